// File: rtl/hazard_ctrl_shadow_if.sv
// rtl/hazard_ctrl_shadow_if.sv - D-stage decode inputs and hazard control outputs of hazard_ctrl_shadow
interface hazard_ctrl_shadow_if #(
    parameter int REG_AW = 5,
    parameter int TW     = 2,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [TW-1:0]     d_tuse_rs;
    logic [TW-1:0]     d_tuse_rt;
    logic [REG_AW-1:0] d_dst;
    logic              d_we;
    logic [TW-1:0]     d_tnew;
    logic              d_md_use;
    logic              d_md_start;
    logic              d_md_div;

    logic              stall;
    logic              en_pc;
    logic              en_d;
    logic              clr_e;
    logic [1:0]        fwd_d_rs;
    logic [1:0]        fwd_d_rt;
    logic [1:0]        fwd_e_rs;
    logic [1:0]        fwd_e_rt;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_we, d_tnew,
               d_md_use, d_md_start, d_md_div,
        input  stall, en_pc, en_d, clr_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt,
               md_busy, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_we, d_tnew,
               d_md_use, d_md_start, d_md_div,
        output stall, en_pc, en_d, clr_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt,
               md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_shadow.sv
// rtl/hazard_ctrl_shadow.sv - MIPS stall/forward controller with E/M/W shadow pipeline; optional HAZARD_STALL_PERF_EN stall counter
module hazard_ctrl_shadow #(
    parameter int REG_AW      = 5,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_shadow_if.slave hz
);
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [REG_AW-1:0] e_dst, e_rs, e_rt, m_dst, w_dst;
    logic              e_we, m_we, w_we;
    logic [TW-1:0]     e_tnew, m_tnew, w_tnew;
    logic [MD_W-1:0]   md_cnt;
    logic              stall;

    function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                                 input logic we);
        return (src != '0) && we && (src == dst);
    endfunction

    // Youngest matching stage wins; if its result is not ready yet, no older stage may be used.
    function automatic logic [1:0] pick(input logic hit_e, input logic rdy_e,
                                        input logic hit_m, input logic rdy_m,
                                        input logic hit_w, input logic rdy_w);
        if (hit_e) return rdy_e ? 2'd3 : 2'd0;
        if (hit_m) return rdy_m ? 2'd2 : 2'd0;
        if (hit_w) return rdy_w ? 2'd1 : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    logic stall_rs, stall_rt, stall_md;

    assign stall_rs = (hit(hz.d_rs, e_dst, e_we) && (hz.d_tuse_rs < e_tnew)) ||
                      (hit(hz.d_rs, m_dst, m_we) && (hz.d_tuse_rs < m_tnew));
    assign stall_rt = (hit(hz.d_rt, e_dst, e_we) && (hz.d_tuse_rt < e_tnew)) ||
                      (hit(hz.d_rt, m_dst, m_we) && (hz.d_tuse_rt < m_tnew));
    assign stall_md = hz.d_md_use && (md_cnt != '0);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign hz.stall = stall;
    assign hz.en_pc = ~stall;
    assign hz.en_d  = ~stall;
    assign hz.clr_e = stall;

    assign hz.fwd_d_rs = pick(hit(hz.d_rs, e_dst, e_we), e_tnew == '0,
                              hit(hz.d_rs, m_dst, m_we), m_tnew == '0,
                              hit(hz.d_rs, w_dst, w_we), w_tnew == '0);
    assign hz.fwd_d_rt = pick(hit(hz.d_rt, e_dst, e_we), e_tnew == '0,
                              hit(hz.d_rt, m_dst, m_we), m_tnew == '0,
                              hit(hz.d_rt, w_dst, w_we), w_tnew == '0);
    assign hz.fwd_e_rs = pick(1'b0, 1'b0,
                              hit(e_rs, m_dst, m_we), m_tnew == '0,
                              hit(e_rs, w_dst, w_we), w_tnew == '0);
    assign hz.fwd_e_rt = pick(1'b0, 1'b0,
                              hit(e_rt, m_dst, m_we), m_tnew == '0,
                              hit(e_rt, w_dst, w_we), w_tnew == '0);

    assign hz.md_busy = (md_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst  <= '0; e_rs <= '0; e_rt <= '0; e_we <= 1'b0; e_tnew <= '0;
            m_dst  <= '0; m_we <= 1'b0; m_tnew <= '0;
            w_dst  <= '0; w_we <= 1'b0; w_tnew <= '0;
            md_cnt <= '0;
        end else begin
            if (stall) begin
                e_dst <= '0; e_rs <= '0; e_rt <= '0; e_we <= 1'b0; e_tnew <= '0;
            end else begin
                e_dst  <= hz.d_dst;
                e_rs   <= hz.d_rs;
                e_rt   <= hz.d_rt;
                e_we   <= hz.d_we;
                e_tnew <= hz.d_tnew;
            end
            m_dst  <= e_dst;
            m_we   <= e_we;
            m_tnew <= age(e_tnew);
            w_dst  <= m_dst;
            w_we   <= m_we;
            w_tnew <= age(m_tnew);
            // A mult/div held in D must not start the MDU until it actually issues.
            if (hz.d_md_start && !stall)
                md_cnt <= hz.d_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - MD_W'(1);
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl_shadow.sv
// tb/tb_hazard_ctrl_shadow.sv - directed scoreboard bench for hazard_ctrl_shadow
module tb_hazard_ctrl_shadow;
    localparam int CNT_W = 32;
`ifdef HAZARD_STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_shadow_if #(.REG_AW(5), .TW(2), .CNT_W(CNT_W)) hz ();

    hazard_ctrl_shadow #(
        .REG_AW(5), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        string            tag;
        logic             st;
        logic [1:0]       fdrs, fdrt, fers, fert;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic chk(input string tag, input string f, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                              input logic [1:0] fers, input logic [1:0] fert, input logic busy);
        exp_t e;
        e.tag = tag; e.st = st; e.fdrs = fdrs; e.fdrt = fdrt; e.fers = fers; e.fert = fert;
        e.busy = busy; e.cnt = PERF ? exp_cnt : '0;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, "stall",     32'(hz.stall),     32'(e.st));
        chk(e.tag, "en_pc",     32'(hz.en_pc),     32'(!e.st));
        chk(e.tag, "en_d",      32'(hz.en_d),      32'(!e.st));
        chk(e.tag, "clr_e",     32'(hz.clr_e),     32'(e.st));
        chk(e.tag, "fwd_d_rs",  32'(hz.fwd_d_rs),  32'(e.fdrs));
        chk(e.tag, "fwd_d_rt",  32'(hz.fwd_d_rt),  32'(e.fdrt));
        chk(e.tag, "fwd_e_rs",  32'(hz.fwd_e_rs),  32'(e.fers));
        chk(e.tag, "fwd_e_rt",  32'(hz.fwd_e_rt),  32'(e.fert));
        chk(e.tag, "md_busy",   32'(hz.md_busy),   32'(e.busy));
        chk(e.tag, "stall_cnt", 32'(hz.stall_cnt), 32'(e.cnt));
    endtask

    // Inputs are already driven; sample at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                        input logic [1:0] fers, input logic [1:0] fert, input logic busy);
        expect_out(tag, st, fdrs, fdrt, fers, fert, busy);
        @(negedge clk);
        check_out();
        if (st && reset) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic d_set(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] dst, input logic we,
                         input logic [1:0] tnew, input logic mdu, input logic mds, input logic mdd);
        hz.d_rs = rs; hz.d_rt = rt; hz.d_tuse_rs = tu_rs; hz.d_tuse_rt = tu_rt;
        hz.d_dst = dst; hz.d_we = we; hz.d_tnew = tnew;
        hz.d_md_use = mdu; hz.d_md_start = mds; hz.d_md_div = mdd;
    endtask

    task automatic nop();
        d_set(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #1;
        step("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // lw $8 ; add $9,$8,$8
        d_set(0, 0, 3, 3, 8, 1, 2, 0, 0, 0);  step("lw8", 0, 0, 0, 0, 0, 0);
        d_set(8, 8, 1, 1, 9, 1, 1, 0, 0, 0);  step("lu_stall", 1, 0, 0, 0, 0, 0);
        step("lu_rel", 0, 0, 0, 0, 0, 0);
        nop();                                step("lu_fwd_e", 0, 0, 0, 1, 1, 0);
        step("lu_drain", 0, 0, 0, 0, 0, 0);

        // addu $3 ; beq $3,$0
        d_set(0, 0, 3, 3, 3, 1, 1, 0, 0, 0);  step("addu3", 0, 0, 0, 0, 0, 0);
        d_set(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("beq_stall", 1, 0, 0, 0, 0, 0);
        step("beq_fwd_m", 0, 2, 0, 0, 0, 0);

        // jal ; jr $31
        d_set(0, 0, 3, 3, 31, 1, 0, 0, 0, 0); step("jal", 0, 0, 0, 1, 0, 0);
        d_set(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); step("jr_fwd_e", 0, 3, 0, 0, 0, 0);

        // lw $5 ; beq $5,$5 stalls two cycles
        d_set(0, 0, 3, 3, 5, 1, 2, 0, 0, 0);  step("lw5", 0, 0, 0, 2, 0, 0);
        d_set(5, 5, 0, 0, 0, 0, 0, 0, 0, 0);  step("beq5_s1", 1, 0, 0, 0, 0, 0);
        step("beq5_s2", 1, 0, 0, 0, 0, 0);
        step("beq5_fwd_w", 0, 1, 1, 0, 0, 0);
        nop();                                step("drain2", 0, 0, 0, 0, 0, 0);

        // $0 is never a hazard
        d_set(0, 0, 3, 3, 0, 1, 2, 0, 0, 0);  step("lw0", 0, 0, 0, 0, 0, 0);
        d_set(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);  step("zero_rd", 0, 0, 0, 0, 0, 0);

        // two writers of $7: E beats M, then M beats W
        d_set(0, 0, 3, 3, 7, 1, 1, 0, 0, 0);  step("w7a", 0, 0, 0, 0, 0, 0);
        d_set(0, 0, 3, 3, 7, 1, 0, 0, 0, 0);  step("w7b", 0, 0, 0, 0, 0, 0);
        d_set(7, 0, 1, 3, 10, 1, 1, 0, 0, 0); step("prio_e", 0, 3, 0, 0, 0, 0);
        nop();                                step("prio_m", 0, 0, 0, 2, 0, 0);
        step("drain3", 0, 0, 0, 0, 0, 0);

        // div then mflo: 10 busy/stall cycles
        d_set(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);  step("div", 0, 0, 0, 0, 0, 0);
        d_set(0, 0, 3, 3, 2, 1, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) step("div_wait", 1, 0, 0, 0, 0, 1);
        step("div_rel", 0, 0, 0, 0, 0, 0);

        // mult then mflo: 5 busy/stall cycles
        d_set(0, 0, 3, 3, 0, 0, 0, 1, 1, 0);  step("mult", 0, 0, 0, 0, 0, 0);
        d_set(0, 0, 3, 3, 2, 1, 1, 1, 0, 0);
        for (int k = 0; k < 5; k++) step("mult_wait", 1, 0, 0, 0, 0, 1);
        step("mult_rel", 0, 0, 0, 0, 0, 0);

        // mult held in D by a load-use stall starts the MDU only when it issues
        d_set(0, 0, 3, 3, 4, 1, 2, 0, 0, 0);  step("lw4", 0, 0, 0, 0, 0, 0);
        d_set(4, 4, 1, 1, 0, 0, 0, 1, 1, 0);  step("mult_held", 1, 0, 0, 0, 0, 0);
        step("mult_issue", 0, 0, 0, 0, 0, 0);
        nop();                                step("mult_busy0", 0, 0, 0, 1, 1, 1);
        for (int k = 0; k < 4; k++) step("mult_busy", 0, 0, 0, 0, 0, 1);
        step("mult_idle", 0, 0, 0, 0, 0, 0);

        // reset in the middle of a div
        d_set(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);  step("div2", 0, 0, 0, 0, 0, 0);
        d_set(0, 0, 3, 3, 2, 1, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step("div2_wait", 1, 0, 0, 0, 0, 1);
        reset = 1'b0;
        #1;
        exp_cnt = '0;
        expect_out("rst_mid", 0, 0, 0, 0, 0, 0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b1;
        nop();

        // three isolated load-use pairs
        for (int p = 0; p < 3; p++) begin
            d_set(0, 0, 3, 3, 8, 1, 2, 0, 0, 0); step("p_lw", 0, 0, 0, 0, 0, 0);
            d_set(8, 8, 1, 1, 9, 1, 1, 0, 0, 0); step("p_stall", 1, 0, 0, 0, 0, 0);
            step("p_rel", 0, 0, 0, 0, 0, 0);
            nop();                               step("p_fwd", 0, 0, 0, 1, 1, 0);
            step("p_gap", 0, 0, 0, 0, 0, 0);
        end
        step("cnt_final", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
